// File: rtl/i2s_audio_ctrl.sv
// rtl/i2s_audio_ctrl.sv - I2S sequencer, clock-enable generator and stereo source arbiter
//
// Purpose: produces the serializer clock-enable from a fractional-N accumulator,
// tracks stereo frame boundaries, pops one stereo sample per frame from two
// valid/ready sources, mixes/selects them and counts source underruns.
//
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   enable                run control; 0 stops ce and clears all sequencing state
//   ce_inc                per-cycle accumulator increment (ce rate = f_clk*ce_inc/2^ACC_W)
//   mode                  00 mute, 01 src0, 10 src1, 11 saturating mix
//   s0_*, s1_*            source streams (valid/ready, signed stereo sample)
//   ce                    clock-enable to serializer
//   left_chan, right_chan sample presented to serializer, updated once per frame
//   frame_tick            one-cycle pulse at each frame boundary
//   underrun              sticky underrun flag
//   underrun_cnt          saturating per-frame underrun count
module i2s_audio_ctrl #(
  parameter int AUDIO_DW = 16,
  parameter int ACC_W    = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [ACC_W-1:0]    ce_inc,
  input  logic [1:0]          mode,
  input  logic                s0_valid,
  output logic                s0_ready,
  input  logic [AUDIO_DW-1:0] s0_left,
  input  logic [AUDIO_DW-1:0] s0_right,
  input  logic                s1_valid,
  output logic                s1_ready,
  input  logic [AUDIO_DW-1:0] s1_left,
  input  logic [AUDIO_DW-1:0] s1_right,
  output logic                ce,
  output logic [AUDIO_DW-1:0] left_chan,
  output logic [AUDIO_DW-1:0] right_chan,
  output logic                frame_tick,
  output logic                underrun,
  output logic [7:0]          underrun_cnt
);

  localparam int                FCNT_W   = $clog2(4 * AUDIO_DW);
  localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(4 * AUDIO_DW - 1);

  localparam logic [AUDIO_DW-1:0] SAMPLE_MAX = {1'b0, {(AUDIO_DW-1){1'b1}}};
  localparam logic [AUDIO_DW-1:0] SAMPLE_MIN = {1'b1, {(AUDIO_DW-1){1'b0}}};

  logic [ACC_W:0]      acc;
  logic [FCNT_W-1:0]   fcnt;
  logic                s0_full, s1_full;
  logic [AUDIO_DW-1:0] s0_hold_l, s0_hold_r, s1_hold_l, s1_hold_r;
  logic                s0_take, s1_take;
  logic [AUDIO_DW-1:0] c0_l, c0_r, c1_l, c1_r;
  logic [AUDIO_DW-1:0] mix_l, mix_r;
  logic                starved;

  // Signed add with clamp to the representable sample range.
  function automatic logic [AUDIO_DW-1:0] sat_add(input logic [AUDIO_DW-1:0] a,
                                                  input logic [AUDIO_DW-1:0] b);
    logic [AUDIO_DW:0] s;
    s = {a[AUDIO_DW-1], a} + {b[AUDIO_DW-1], b};
    if (s[AUDIO_DW] != s[AUDIO_DW-1])
      return s[AUDIO_DW] ? SAMPLE_MIN : SAMPLE_MAX;
    return s[AUDIO_DW-1:0];
  endfunction

  // The carry is kept as the top accumulator bit and ce is registered from it,
  // so ce lags the overflow by one cycle and is a clean single-cycle pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      ce  <= 1'b0;
    end else if (!enable) begin
      acc <= '0;
      ce  <= 1'b0;
    end else begin
      acc <= {1'b0, acc[ACC_W-1:0]} + {1'b0, ce_inc};
      ce  <= acc[ACC_W];
    end
  end

  // Frame position: 2 channels x AUDIO_DW bits x 2 ce per bit clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fcnt       <= '0;
      frame_tick <= 1'b0;
    end else if (!enable) begin
      fcnt       <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= ce && (fcnt == FCNT_MAX);
      if (ce)
        fcnt <= (fcnt == FCNT_MAX) ? '0 : fcnt + 1'b1;
    end
  end

  assign s0_ready = ~s0_full;
  assign s1_ready = ~s1_full;
  assign s0_take  = s0_valid & ~s0_full;
  assign s1_take  = s1_valid & ~s1_full;

  // One-entry hold per source. A load always wins over frame consumption: a
  // load can only happen while empty, so the new sample waits for the next frame.
  // While disabled the holds are kept empty and offered samples are discarded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0_full   <= 1'b0;
      s1_full   <= 1'b0;
      s0_hold_l <= '0;
      s0_hold_r <= '0;
      s1_hold_l <= '0;
      s1_hold_r <= '0;
    end else if (!enable) begin
      s0_full <= 1'b0;
      s1_full <= 1'b0;
    end else begin
      if (s0_take) begin
        s0_full   <= 1'b1;
        s0_hold_l <= s0_left;
        s0_hold_r <= s0_right;
      end else if (frame_tick) begin
        s0_full <= 1'b0;
      end
      if (s1_take) begin
        s1_full   <= 1'b1;
        s1_hold_l <= s1_left;
        s1_hold_r <= s1_right;
      end else if (frame_tick) begin
        s1_full <= 1'b0;
      end
    end
  end

  // Unselected or empty sources contribute zero, so a single saturating adder
  // covers mute, single-source and mix modes alike.
  always_comb begin
    c0_l    = (mode[0] && s0_full) ? s0_hold_l : '0;
    c0_r    = (mode[0] && s0_full) ? s0_hold_r : '0;
    c1_l    = (mode[1] && s1_full) ? s1_hold_l : '0;
    c1_r    = (mode[1] && s1_full) ? s1_hold_r : '0;
    mix_l   = sat_add(c0_l, c1_l);
    mix_r   = sat_add(c0_r, c1_r);
    starved = (mode[0] && !s0_full) || (mode[1] && !s1_full);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      left_chan    <= '0;
      right_chan   <= '0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else if (!enable) begin
      left_chan    <= '0;
      right_chan   <= '0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else if (frame_tick) begin
      left_chan  <= mix_l;
      right_chan <= mix_r;
      if (starved) begin
        underrun <= 1'b1;
        if (underrun_cnt != 8'hFF)
          underrun_cnt <= underrun_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_audio_ctrl.sv
// tb/tb_i2s_audio_ctrl.sv - directed self-checking bench for i2s_audio_ctrl
module tb_i2s_audio_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [23:0] ce_inc;
  logic [1:0]  mode;
  logic        s0_valid, s1_valid;
  logic        s0_ready, s1_ready;
  logic [15:0] s0_left, s0_right, s1_left, s1_right;
  logic        ce;
  logic [15:0] left_chan, right_chan;
  logic        frame_tick;
  logic        underrun;
  logic [7:0]  underrun_cnt;

  int checks = 0;
  int errors = 0;
  int n;
  int n_ce;

  i2s_audio_ctrl #(.AUDIO_DW(16), .ACC_W(24)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .ce_inc(ce_inc), .mode(mode),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_left(s0_left), .s0_right(s0_right),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_left(s1_left), .s1_right(s1_right),
    .ce(ce), .left_chan(left_chan), .right_chan(right_chan), .frame_tick(frame_tick),
    .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic v0, input logic [15:0] l0, input logic [15:0] r0,
                      input logic v1, input logic [15:0] l1, input logic [15:0] r1);
    s0_valid = v0; s0_left = l0; s0_right = r0;
    s1_valid = v1; s1_left = l1; s1_right = r1;
    tick();
    s0_valid = 1'b0;
    s1_valid = 1'b0;
  endtask

  task automatic wait_frame(output int cycles);
    cycles = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      cycles++;
      if (frame_tick === 1'b1) break;
    end
    check("frame_tick_seen", 32'(frame_tick), 32'd1);
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; ce_inc = '0; mode = 2'b00;
    s0_valid = 1'b0; s1_valid = 1'b0;
    s0_left = '0; s0_right = '0; s1_left = '0; s1_right = '0;
    #12;
    check("rst_ce",       32'(ce), 32'd0);
    check("rst_left",     32'(left_chan), 32'd0);
    check("rst_right",    32'(right_chan), 32'd0);
    check("rst_s0_ready", 32'(s0_ready), 32'd1);
    check("rst_s1_ready", 32'(s1_ready), 32'd1);
    check("rst_tick",     32'(frame_tick), 32'd0);
    check("rst_und",      32'(underrun), 32'd0);
    check("rst_cnt",      32'(underrun_cnt), 32'd0);
    reset_n = 1'b1;
    tick(); tick();

    // ce latency, frame period, mode 01 with source 0 only
    enable = 1'b1; ce_inc = 24'h400000; mode = 2'b01;
    s0_valid = 1'b1; s0_left = 16'h1234; s0_right = 16'hABCD;
    tick(); n = 1;
    s0_valid = 1'b0;
    check("s0_full_after_load", 32'(s0_ready), 32'd0);
    while (ce !== 1'b1 && n < 20) begin tick(); n++; end
    check("first_ce_cycle", 32'(n), 32'd5);
    while (frame_tick !== 1'b1 && n < 400) begin tick(); n++; end
    check("first_frame_cycle", 32'(n), 32'd258);
    check("left_before_latency", 32'(left_chan), 32'd0);
    tick();
    check("m01_left",  32'(left_chan), 32'h1234);
    check("m01_right", 32'(right_chan), 32'hABCD);
    check("m01_und",   32'(underrun), 32'd0);
    check("m01_ready", 32'(s0_ready), 32'd1);
    mode = 2'b00;
    wait_frame(n);
    check("frame_period", 32'(n + 1), 32'd256);
    tick();
    check("mute_left", 32'(left_chan), 32'd0);
    check("mute_und",  32'(underrun), 32'd0);

    // saturating mix, both directions
    mode = 2'b11;
    push(1'b1, 16'h7000, 16'h8100, 1'b1, 16'h2000, 16'hF000);
    wait_frame(n); tick();
    check("sat_left",  32'(left_chan), 32'h7FFF);
    check("sat_right", 32'(right_chan), 32'h8000);
    check("sat_und",   32'(underrun), 32'd0);
    check("sat_s1_ready", 32'(s1_ready), 32'd1);
    push(1'b1, 16'h0100, 16'hFFFF, 1'b1, 16'h0200, 16'h0001);
    wait_frame(n); tick();
    check("mix_left",  32'(left_chan), 32'h0300);
    check("mix_right", 32'(right_chan), 32'h0000);

    // mode 10 consumes the unused source 0 as well
    mode = 2'b10;
    push(1'b1, 16'h1111, 16'h2222, 1'b1, 16'h5555, 16'hAAAA);
    wait_frame(n); tick();
    check("m10_left",  32'(left_chan), 32'h5555);
    check("m10_right", 32'(right_chan), 32'hAAAA);
    check("m10_s0_consumed", 32'(s0_ready), 32'd1);
    mode = 2'b01;
    wait_frame(n); tick();
    check("m01_empty_left", 32'(left_chan), 32'd0);
    check("m01_empty_und",  32'(underrun), 32'd1);
    check("m01_empty_cnt",  32'(underrun_cnt), 32'd1);

    // underrun counting and saturation
    enable = 1'b0; tick();
    check("dis_und", 32'(underrun), 32'd0);
    check("dis_cnt", 32'(underrun_cnt), 32'd0);
    enable = 1'b1; mode = 2'b11;
    for (int f = 1; f <= 3; f++) begin
      push(1'b1, 16'h0123, 16'hFEDC, 1'b0, 16'h0, 16'h0);
      wait_frame(n); tick();
    end
    check("und3_flag",  32'(underrun), 32'd1);
    check("und3_cnt",   32'(underrun_cnt), 32'd3);
    check("und3_left",  32'(left_chan), 32'h0123);
    check("und3_right", 32'(right_chan), 32'hFEDC);
    ce_inc = 24'hFFFFFF;
    for (int f = 4; f <= 300; f++) begin
      wait_frame(n); tick();
      if (f == 254) check("und254_cnt", 32'(underrun_cnt), 32'd254);
      if (f == 256) check("und256_cnt", 32'(underrun_cnt), 32'd255);
    end
    check("und300_cnt", 32'(underrun_cnt), 32'd255);

    // valid held across a frame boundary
    enable = 1'b0; tick();
    enable = 1'b1; ce_inc = 24'h400000; mode = 2'b11;
    s0_valid = 1'b1; s0_left = 16'h0A0A; s0_right = 16'h0B0B;
    tick();
    wait_frame(n);
    check("hold_ready_at_tick", 32'(s0_ready), 32'd0);
    s0_left = 16'h0C0C; s0_right = 16'h0D0D;
    tick();
    check("hold_ready_after", 32'(s0_ready), 32'd1);
    check("hold_left_a", 32'(left_chan), 32'h0A0A);
    tick();
    check("hold_ready_reload", 32'(s0_ready), 32'd0);
    s0_valid = 1'b0;
    wait_frame(n); tick();
    check("hold_left_b",  32'(left_chan), 32'h0C0C);
    check("hold_right_b", 32'(right_chan), 32'h0D0D);
    check("hold_cnt",     32'(underrun_cnt), 32'd2);

    // enable dropped mid-frame
    for (int i = 0; i < 100; i++) tick();
    push(1'b1, 16'h0E0E, 16'h0F0F, 1'b0, 16'h0, 16'h0);
    check("pre_drop_ready", 32'(s0_ready), 32'd0);
    check("pre_drop_und",   32'(underrun), 32'd1);
    enable = 1'b0; tick();
    check("drop_ce",    32'(ce), 32'd0);
    check("drop_left",  32'(left_chan), 32'd0);
    check("drop_right", 32'(right_chan), 32'd0);
    check("drop_ready", 32'(s0_ready), 32'd1);
    check("drop_und",   32'(underrun), 32'd0);
    check("drop_cnt",   32'(underrun_cnt), 32'd0);
    n_ce = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (ce === 1'b1) n_ce++; end
    check("drop_no_ce", 32'(n_ce), 32'd0);
    enable = 1'b1; n = 0; n_ce = 0;
    while (frame_tick !== 1'b1 && n < 400) begin tick(); n++; if (ce === 1'b1) n_ce++; end
    check("reen_ce_count", 32'(n_ce), 32'd64);
    check("reen_cycles",   32'(n), 32'd258);

    // sample offered in the frame_tick cycle is kept for the next frame
    push(1'b1, 16'h1357, 16'h2468, 1'b0, 16'h0, 16'h0);
    check("tick_load_kept", 32'(s0_ready), 32'd0);
    check("tick_load_left", 32'(left_chan), 32'd0);
    check("tick_load_cnt",  32'(underrun_cnt), 32'd1);
    wait_frame(n); tick();
    check("kept_left",  32'(left_chan), 32'h1357);
    check("kept_right", 32'(right_chan), 32'h2468);
    check("kept_cnt",   32'(underrun_cnt), 32'd2);

    // asynchronous reset mid-frame
    for (int i = 0; i < 20; i++) tick();
    #3 reset_n = 1'b0;
    #1;
    check("arst_left",  32'(left_chan), 32'd0);
    check("arst_right", 32'(right_chan), 32'd0);
    check("arst_ready", 32'(s0_ready), 32'd1);
    check("arst_und",   32'(underrun), 32'd0);
    check("arst_cnt",   32'(underrun_cnt), 32'd0);
    check("arst_ce",    32'(ce), 32'd0);
    enable = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
